muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit for the MIPS datapath, sitting beside the ALU in the execute stage. It consumes the same operand pair and function code that feed the ALU and handles `mult`/`multu`/`div`/`divu` over 32 cycles, holding results in architectural HI/LO registers. It returns HI or LO to writeback for `mfhi`/`mflo`. A start/busy/done handshake lets the pipeline controller stall while an operation is in flight.

## Interface

Parameters:
- `WIDTH`, 32: operand and HI/LO width; the iteration count equals `WIDTH`.

Ports:
- `clk`: input, 1. Clock; all state updates on the rising edge.
- `rst`: input, 1. Synchronous, active-high reset.
- `start`: input, 1. Request an operation; sampled only when `busy`=0.
- `func`: input, 6. Function code: `mult`=011000, `multu`=011001, `div`=011010, `divu`=011011, `mfhi`=010000, `mflo`=010010.
- `input1`: input, 32. Multiplicand or dividend (rs).
- `input2`: input, 32. Multiplier or divisor (rt).
- `busy`: output, 1. High while an operation is in flight.
- `done`: output, 1. One-cycle pulse when HI/LO have just been written.
- `div_by_zero`: output, 1. Qualified by `done`; high for a divide with `input2`=0.
- `hi`: output, 32. HI register.
- `lo`: output, 32. LO register.
- `out`: output, 32. Combinational read: `hi` if `func`=`mfhi`, `lo` if `func`=`mflo`, else 0.

## Operation

- States are IDLE, RUN and FIN.
  - In IDLE with `start`=1 and a mul/div `func`, the unit latches the operand magnitudes, the sign flags (signed ops only) and the op type, clears the counter, and goes to RUN.
  - In IDLE with `start`=1 and any other `func`, nothing happens.
- Multiply is radix-2 shift-add over a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- Divide is restoring division: one quotient bit per cycle, MSB first, with a 33-bit partial remainder.
- The signed ops (`mult`, `div`) run on magnitudes, and the sign is fixed when results are written:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Result mapping:
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
- The counter runs 0..31. The edge that completes iteration 31 writes HI/LO and moves to FIN.
- FIN lasts one cycle with `done`=1, then the unit returns to IDLE.
- Divide by zero: at the accepting edge the unit goes straight to FIN and writes HI = `input1`, LO = 32'hFFFFFFFF. It raises `div_by_zero` with `done`.
- Signed overflow, -2^31 / -1, gives LO = 32'h80000000 and HI = 0. This is the natural result of the magnitude algorithm; no flag is raised.
- HI/LO change only at result write or reset. `mfhi`/`mflo` during RUN return the previous values; the controller is responsible for stalling.
- `start` while `busy`=1 is ignored. Operands are not re-sampled during RUN.

## Timing

- Reset values: `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- Accepting edge E0: `busy`=1 from just after E0.
- Edge E32 completes the last iteration: `hi`/`lo` are valid after E32, and `done`=1 and `busy`=0 for the cycle after E32. Start-to-result latency is therefore 32 cycles.
- Divide by zero: results are written at E0, and `done` is high for the cycle after E0. `busy` stays 0.
- A new `start` is accepted in the same cycle that `done` is high (FIN counts as not busy). Back-to-back operations are 33 cycles apart.
- `rst` during RUN or FIN aborts the operation: no `done`, HI/LO cleared, state IDLE after that edge.
- `out` is purely combinational from `func`, `hi` and `lo`, with zero latency.

## Test plan

- `multu` 7 × 6 → after 32 cycles `done` pulses, `hi`=0, `lo`=42. `busy` is high for exactly 32 cycles.
- `mult` -3 × 5 → `hi`=FFFFFFFF, `lo`=FFFFFFF1. `multu` FFFFFFFF × FFFFFFFF → `hi`=FFFFFFFE, `lo`=00000001.
- `div` -7 / 2 → `lo`=FFFFFFFD, `hi`=FFFFFFFF. `divu` 100 / 7 → `lo`=14, `hi`=2. `div` 80000000 / FFFFFFFF → `lo`=80000000, `hi`=0.
- `divu` 5 / 0 → `done` the cycle after acceptance with `div_by_zero`=1, `hi`=5, `lo`=FFFFFFFF, `busy` never high.
- Second `start` (`multu` 2 × 2) issued mid-RUN of `multu` 3 × 3 is ignored and `lo`=9. `rst` asserted 10 cycles into a `div` → no `done`, and `hi`, `lo` and `busy` are all 0.
- After `multu` 7 × 6 completes: `func`=`mflo` → `out`=42; `func`=`mfhi` → `out`=0; `func`=`addu` (100001) → `out`=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t state;

    logic             op_div;
    logic             neg_q;
    logic             neg_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opnd;
    logic [2*WIDTH-1:0] acc;

    logic             is_mul;
    logic             is_div;
    logic             is_signed;
    logic             sign1;
    logic             sign2;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;

    always_comb begin
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        case (func)
            F_MULT: begin
                is_mul    = 1'b1;
                is_signed = 1'b1;
            end
            F_MULTU: is_mul = 1'b1;
            F_DIV: begin
                is_div    = 1'b1;
                is_signed = 1'b1;
            end
            F_DIVU: is_div = 1'b1;
            default: ;
        endcase
    end

    assign sign1 = is_signed & input1[WIDTH-1];
    assign sign2 = is_signed & input2[WIDTH-1];
    assign mag1  = sign1 ? -input1 : input1;
    assign mag2  = sign2 ? -input2 : input2;

    // acc holds {partial product, multiplier} for multiply and
    // {remainder, dividend/quotient} for divide
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] acc_next;

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = {1'b0, div_shift} - {2'b00, opnd};
        if (!op_div)
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        else if (div_diff[WIDTH+1])
            acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_raw;
    logic [WIDTH-1:0]   rem_raw;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        prod_fix = neg_q ? -acc_next : acc_next;
        quo_raw  = acc_next[WIDTH-1:0];
        rem_raw  = acc_next[2*WIDTH-1:WIDTH];
        quo_fix  = neg_q ? -quo_raw : quo_raw;
        rem_fix  = neg_r ? -rem_raw : rem_raw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            cnt         <= '0;
            acc         <= '0;
            opnd        <= '0;
            op_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    state       <= IDLE;
                    done        <= 1'b0;
                    div_by_zero <= 1'b0;
                    if (start && (is_mul || is_div)) begin
                        if (is_div && input2 == '0) begin
                            hi          <= input1;
                            lo          <= '1;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            state       <= FIN;
                        end else begin
                            op_div <= is_div;
                            neg_q  <= sign1 ^ sign2;
                            neg_r  <= sign1;
                            opnd   <= is_div ? mag2 : mag1;
                            acc    <= {{WIDTH{1'b0}},
                                       (is_div ? mag1 : mag2)};
                            cnt    <= '0;
                            busy   <= 1'b1;
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                        if (op_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        out = '0;
        if (func == F_MFHI)
            out = hi;
        else if (func == F_MFLO)
            out = lo;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: mul/div results, latency,
// divide by zero, ignored start, reset abort and HI/LO reads.
module tb_muldiv_unit;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADDU  = 6'b100001;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  func;
    logic [31:0] input1;
    logic [31:0] input2;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] out;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .func        (func),
        .input1      (input1),
        .input2      (input2),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo),
        .out         (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic start_op(input logic [5:0] f, input logic [31:0] a,
                            input logic [31:0] b);
        @(negedge clk);
        func   = f;
        input1 = a;
        input2 = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (!done && cyc < 40) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic do_op(input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b,
                         output int cyc, output int bcnt);
        start_op(f, a, b);
        wait_done(cyc, bcnt);
    endtask

    initial begin
        int cyc;
        int bcnt;
        int dn;

        rst    = 1'b1;
        start  = 1'b0;
        func   = '0;
        input1 = '0;
        input2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op(F_MULTU, 32'd7, 32'd6, cyc, bcnt);
        check("multu_lat", 32'(cyc), 32'd32);
        check("multu_busy", 32'(bcnt), 32'd32);
        check("multu_hi", hi, 32'd0);
        check("multu_lo", lo, 32'd42);
        check("multu_dbz", 32'(div_by_zero), 32'd0);
        func = F_MFLO;
        #1;
        check("mflo", out, 32'd42);
        func = F_MFHI;
        #1;
        check("mfhi", out, 32'd0);
        func = F_ADDU;
        #1;
        check("addu_out", out, 32'd0);
        @(posedge clk);
        #1;
        check("done_pulse", 32'(done), 32'd0);

        do_op(F_MULT, 32'hFFFF_FFFD, 32'd5, cyc, bcnt);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFF1);

        do_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bcnt);
        check("multu_max_hi", hi, 32'hFFFF_FFFE);
        check("multu_max_lo", lo, 32'h0000_0001);

        do_op(F_DIV, 32'hFFFF_FFF9, 32'd2, cyc, bcnt);
        check("div_neg_lat", 32'(cyc), 32'd32);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);

        do_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bcnt);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'd0);
        check("div_ovf_dbz", 32'(div_by_zero), 32'd0);

        do_op(F_DIVU, 32'd5, 32'd0, cyc, bcnt);
        check("dbz_lat", 32'(cyc), 32'd0);
        check("dbz_busy_cnt", 32'(bcnt), 32'd0);
        check("dbz_busy", 32'(busy), 32'd0);
        check("dbz_flag", 32'(div_by_zero), 32'd1);
        check("dbz_hi", hi, 32'd5);
        check("dbz_lo", lo, 32'hFFFF_FFFF);

        start_op(F_MULTU, 32'd3, 32'd3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        input1 = 32'd2;
        input2 = 32'd2;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc, bcnt);
        check("ign_lo", lo, 32'd9);
        check("ign_hi", hi, 32'd0);

        do_op(F_DIVU, 32'd100, 32'd7, cyc, bcnt);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        start_op(F_DIV, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        dn = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        check("abort_no_done", 32'(dn), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
